// File: rtl/id_ex_stage_if.sv
// Decode-side and EX-side signal bundle for the ID/EX pipeline stage.
// slave = the stage itself; master = whatever drives decode (core or bench).
interface id_ex_stage_if #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs1;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs2;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRd;
  logic                  ID_RegWrite;
  logic                  ID_MemRead;
  logic                  ID_MemWrite;
  logic                  ID_MemtoReg;
  logic                  ID_Branch;
  logic                  ID_ALUSrc;
  logic [1:0]            ID_ALUOp;
  logic [3:0]            ID_Funct;
  logic [DATA_W-1:0]     ID_ReadData1;
  logic [DATA_W-1:0]     ID_ReadData2;
  logic [DATA_W-1:0]     ID_Imm;
  logic [DATA_W-1:0]     ID_PC;
  logic                  flush;
  logic                  hold;

  logic [REG_ADDR_W-1:0] ID_EX_RegisterRs1;
  logic [REG_ADDR_W-1:0] ID_EX_RegisterRs2;
  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd;
  logic                  ID_EX_RegWrite;
  logic                  ID_EX_MemRead;
  logic                  ID_EX_MemWrite;
  logic                  ID_EX_MemtoReg;
  logic                  ID_EX_Branch;
  logic                  ID_EX_ALUSrc;
  logic [1:0]            ID_EX_ALUOp;
  logic [3:0]            ID_EX_Funct;
  logic [DATA_W-1:0]     ID_EX_ReadData1;
  logic [DATA_W-1:0]     ID_EX_ReadData2;
  logic [DATA_W-1:0]     ID_EX_Imm;
  logic [DATA_W-1:0]     ID_EX_PC;
  logic                  ID_EX_Valid;
  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      bubble_count;

  modport slave (
    input  IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd,
    input  ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc,
    input  ID_ALUOp, ID_Funct, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC,
    input  flush, hold,
    output ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd,
    output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
    output ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_Funct,
    output ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC, ID_EX_Valid,
    output PCWrite, IF_ID_Write, stall_count, bubble_count
  );

  modport master (
    output IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd,
    output ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc,
    output ID_ALUOp, ID_Funct, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC,
    output flush, hold,
    input  ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd,
    input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
    input  ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_Funct,
    input  ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC, ID_EX_Valid,
    input  PCWrite, IF_ID_Write, stall_count, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, global hold and saturating stall/bubble counters.
module id_ex_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           reset,
  id_ex_stage_if.slave   bus
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic [3:0]            funct;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     pc;
    logic                  valid;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             lu;
  logic             upstream_adv;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard looks only at registered EX state, so it cannot loop through PCWrite.
  assign lu = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
              ((ex_q.rd == bus.IF_ID_RegisterRs1) | (ex_q.rd == bus.IF_ID_RegisterRs2));

  // A taken branch must let fetch advance to the target even if decode would stall.
  assign upstream_adv    = reset | ~(bus.hold | (lu & ~bus.flush));
  assign bus.PCWrite     = upstream_adv;
  assign bus.IF_ID_Write = upstream_adv;

  always_comb begin
    ex_d     = ex_q;
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (bus.flush) begin
      ex_d     = '0;
      bubble_d = sat_inc(bubble_q);
    end else if (bus.hold) begin
      ex_d     = ex_q;
    end else if (lu) begin
      ex_d     = '0;
      stall_d  = sat_inc(stall_q);
      bubble_d = sat_inc(bubble_q);
    end else begin
      ex_d.rs1        = bus.IF_ID_RegisterRs1;
      ex_d.rs2        = bus.IF_ID_RegisterRs2;
      ex_d.rd         = bus.IF_ID_RegisterRd;
      ex_d.reg_write  = bus.ID_RegWrite;
      ex_d.mem_read   = bus.ID_MemRead;
      ex_d.mem_write  = bus.ID_MemWrite;
      ex_d.mem_to_reg = bus.ID_MemtoReg;
      ex_d.branch     = bus.ID_Branch;
      ex_d.alu_src    = bus.ID_ALUSrc;
      ex_d.alu_op     = bus.ID_ALUOp;
      ex_d.funct      = bus.ID_Funct;
      ex_d.rdata1     = bus.ID_ReadData1;
      ex_d.rdata2     = bus.ID_ReadData2;
      ex_d.imm        = bus.ID_Imm;
      ex_d.pc         = bus.ID_PC;
      ex_d.valid      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q     <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      ex_q     <= ex_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.ID_EX_RegisterRs1 = ex_q.rs1;
  assign bus.ID_EX_RegisterRs2 = ex_q.rs2;
  assign bus.ID_EX_RegisterRd  = ex_q.rd;
  assign bus.ID_EX_RegWrite    = ex_q.reg_write;
  assign bus.ID_EX_MemRead     = ex_q.mem_read;
  assign bus.ID_EX_MemWrite    = ex_q.mem_write;
  assign bus.ID_EX_MemtoReg    = ex_q.mem_to_reg;
  assign bus.ID_EX_Branch      = ex_q.branch;
  assign bus.ID_EX_ALUSrc      = ex_q.alu_src;
  assign bus.ID_EX_ALUOp       = ex_q.alu_op;
  assign bus.ID_EX_Funct       = ex_q.funct;
  assign bus.ID_EX_ReadData1   = ex_q.rdata1;
  assign bus.ID_EX_ReadData2   = ex_q.rdata2;
  assign bus.ID_EX_Imm         = ex_q.imm;
  assign bus.ID_EX_PC          = ex_q.pc;
  assign bus.ID_EX_Valid       = ex_q.valid;
  assign bus.stall_count       = stall_q;
  assign bus.bubble_count      = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold/reset cases plus a random
// stream, all checked each cycle against a word-level model of the stage.
module tb_id_ex_stage;
  localparam int DW   = 64;
  localparam int RW   = 5;
  localparam int CW   = 6;  // narrow counters so saturation is reachable quickly
  localparam int MAXC = (1 << CW) - 1;
  localparam int WW   = 3*RW + 12 + 4*DW;

  logic clk = 1'b0;
  logic reset;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  bit   chk_en    = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_ADDR_W(RW), .CNT_W(CW)) bus ();
  id_ex_stage    #(.DATA_W(DW), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  // model: what EX should hold, as one word laid out like dec_word()
  logic [WW-1:0] m_word;
  logic          m_valid;
  int            m_stall, m_bubble;

  function automatic logic [WW-1:0] dec_word();
    return {bus.IF_ID_RegisterRs1, bus.IF_ID_RegisterRs2, bus.IF_ID_RegisterRd,
            bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite, bus.ID_MemtoReg,
            bus.ID_Branch, bus.ID_ALUSrc, bus.ID_ALUOp, bus.ID_Funct,
            bus.ID_ReadData1, bus.ID_ReadData2, bus.ID_Imm, bus.ID_PC};
  endfunction

  function automatic logic [WW-1:0] ex_word();
    return {bus.ID_EX_RegisterRs1, bus.ID_EX_RegisterRs2, bus.ID_EX_RegisterRd,
            bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_MemtoReg,
            bus.ID_EX_Branch, bus.ID_EX_ALUSrc, bus.ID_EX_ALUOp, bus.ID_EX_Funct,
            bus.ID_EX_ReadData1, bus.ID_EX_ReadData2, bus.ID_EX_Imm, bus.ID_EX_PC};
  endfunction

  function automatic bit model_lu();
    logic [RW-1:0] rd;
    rd = m_word[WW-2*RW-1 -: RW];
    return m_valid && m_word[4*DW+10] && rd != 0 &&
           (rd == bus.IF_ID_RegisterRs1 || rd == bus.IF_ID_RegisterRs2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_word = '0; m_valid = 1'b0; m_stall = 0; m_bubble = 0;
    end else if (bus.flush) begin
      m_word = '0; m_valid = 1'b0;
      if (m_bubble < MAXC) m_bubble++;
    end else if (bus.hold) begin
      m_word = m_word;
    end else if (model_lu()) begin
      m_word = '0; m_valid = 1'b0;
      if (m_stall < MAXC) m_stall++;
      if (m_bubble < MAXC) m_bubble++;
    end else begin
      m_word = dec_word(); m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [WW-1:0] w;
      bit exp_pcw;
      w = ex_word();
      exp_pcw = reset || !(bus.hold || (model_lu() && !bus.flush));
      chk("cyc_idx",    64'(w[WW-1 -: 3*RW]),   64'(m_word[WW-1 -: 3*RW]));
      chk("cyc_ctrl",   64'(w[4*DW+11:4*DW]),   64'(m_word[4*DW+11:4*DW]));
      chk("cyc_rdata1", w[4*DW-1:3*DW],         m_word[4*DW-1:3*DW]);
      chk("cyc_rdata2", w[3*DW-1:2*DW],         m_word[3*DW-1:2*DW]);
      chk("cyc_imm",    w[2*DW-1:DW],           m_word[2*DW-1:DW]);
      chk("cyc_pc",     w[DW-1:0],              m_word[DW-1:0]);
      chk("cyc_valid",  64'(bus.ID_EX_Valid),   64'(m_valid));
      chk("cyc_pcw",    64'(bus.PCWrite),       64'(exp_pcw));
      chk("cyc_ifidw",  64'(bus.IF_ID_Write),   64'(exp_pcw));
      chk("cyc_stall",  64'(bus.stall_count),   64'(m_stall));
      chk("cyc_bubble", 64'(bus.bubble_count),  64'(m_bubble));
    end
  end

  task automatic set_instr(input int rs1, input int rs2, input int rd,
                           input bit mrd, input logic [63:0] d1);
    bus.IF_ID_RegisterRs1 = RW'(rs1);
    bus.IF_ID_RegisterRs2 = RW'(rs2);
    bus.IF_ID_RegisterRd  = RW'(rd);
    bus.ID_MemRead   = mrd;
    bus.ID_RegWrite  = 1'b1;
    bus.ID_MemtoReg  = mrd;
    bus.ID_MemWrite  = 1'($urandom_range(0, 1));
    bus.ID_Branch    = 1'($urandom_range(0, 1));
    bus.ID_ALUSrc    = 1'($urandom_range(0, 1));
    bus.ID_ALUOp     = 2'($urandom_range(0, 3));
    bus.ID_Funct     = 4'($urandom_range(0, 15));
    bus.ID_ReadData1 = d1;
    bus.ID_ReadData2 = {$urandom, $urandom};
    bus.ID_Imm       = {$urandom, $urandom};
    bus.ID_PC        = {$urandom, $urandom};
  endtask

  // advance to 2 time units after the next rising edge, where inputs change
  task automatic next_cyc();
    @(posedge clk); #2;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.hold = 1'b1;
    set_instr(0, 0, 0, 1'b0, 64'h0);
    #1;
    chk("rst_pcw_hold", 64'(bus.PCWrite), 64'h1);
    chk("rst_valid",    64'(bus.ID_EX_Valid), 64'h0);
    bus.hold = 1'b0;
    repeat (2) next_cyc();
    reset = 1'b0;
    chk_en = 1'b1;

    // x0 load and non-load producers never stall
    set_instr(1, 2, 0, 1'b1, 64'h11);
    next_cyc();
    set_instr(0, 0, 7, 1'b0, 64'h22);
    #1 chk("x0_pcw", 64'(bus.PCWrite), 64'h1);
    #1 set_instr(3, 4, 5, 1'b0, 64'h33);
    next_cyc();
    set_instr(5, 5, 8, 1'b0, 64'h44);
    #1 chk("add_pcw", 64'(bus.PCWrite), 64'h1);
    next_cyc();
    chk("nolu_stall", 64'(bus.stall_count), 64'h0);

    // classic load-use
    set_instr(1, 2, 5, 1'b1, 64'h55);
    next_cyc();
    chk("ld_rd",  64'(bus.ID_EX_RegisterRd), 64'h5);
    chk("ld_mrd", 64'(bus.ID_EX_MemRead), 64'h1);
    set_instr(5, 9, 6, 1'b0, 64'h1234);
    #1 chk("lu_pcw",  64'(bus.PCWrite), 64'h0);
    chk("lu_ifidw", 64'(bus.IF_ID_Write), 64'h0);
    next_cyc();
    chk("lu_bub_valid", 64'(bus.ID_EX_Valid), 64'h0);
    chk("lu_bub_mrd",   64'(bus.ID_EX_MemRead), 64'h0);
    chk("lu_stall1",    64'(bus.stall_count), 64'h1);
    chk("lu_pcw_after", 64'(bus.PCWrite), 64'h1);
    next_cyc();
    chk("dep_valid", 64'(bus.ID_EX_Valid), 64'h1);
    chk("dep_rd1",   bus.ID_EX_ReadData1, 64'h1234);

    // flush beats load-use
    set_instr(1, 2, 5, 1'b1, 64'h66);
    next_cyc();
    set_instr(5, 0, 6, 1'b0, 64'h77);
    bus.flush = 1'b1;
    #1 chk("fl_pcw", 64'(bus.PCWrite), 64'h1);
    next_cyc();
    bus.flush = 1'b0;
    chk("fl_valid",  64'(bus.ID_EX_Valid), 64'h0);
    chk("fl_bubble", 64'(bus.bubble_count), 64'h2);
    chk("fl_stall",  64'(bus.stall_count), 64'h1);

    // hold freezes the stage for three edges
    set_instr(10, 11, 12, 1'b0, 64'hDEAD_BEEF);
    next_cyc();
    set_instr(13, 14, 15, 1'b0, 64'h9999);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_pcw", 64'(bus.PCWrite), 64'h0);
      next_cyc();
      chk("hold_rd1",    bus.ID_EX_ReadData1, 64'hDEAD_BEEF);
      chk("hold_bubble", 64'(bus.bubble_count), 64'h2);
    end
    bus.hold = 1'b0;
    set_instr(1, 1, 1, 1'b0, 64'hCAFE);
    next_cyc();
    chk("unhold_rd1", bus.ID_EX_ReadData1, 64'hCAFE);

    // random stream, small register range so hazards are frequent
    for (int i = 0; i < 2000; i++) begin
      set_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), {$urandom, $urandom});
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.hold  = ($urandom_range(0, 6) == 0);
      next_cyc();
    end
    bus.flush = 1'b0; bus.hold = 1'b0;

    // saturation: self-dependent load stalls every other cycle
    reset = 1'b1;
    #1 reset = 1'b0;
    set_instr(5, 0, 5, 1'b1, 64'h5A);
    for (int i = 0; i < 140; i++) next_cyc();
    chk("sat_stall",  64'(bus.stall_count), 64'(MAXC));
    chk("sat_bubble", 64'(bus.bubble_count), 64'(MAXC));

    // reset in the middle of a stall
    set_instr(1, 2, 5, 1'b1, 64'h88);
    while (!(bus.ID_EX_Valid && bus.ID_EX_MemRead)) next_cyc();
    set_instr(5, 2, 6, 1'b0, 64'hABCD);
    #1 chk("mid_pcw_pre", 64'(bus.PCWrite), 64'h0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.ID_EX_Valid), 64'h0);
    chk("mid_rst_rd",    64'(bus.ID_EX_RegisterRd), 64'h0);
    chk("mid_rst_stall", 64'(bus.stall_count), 64'h0);
    chk("mid_rst_pcw",   64'(bus.PCWrite), 64'h1);
    next_cyc();
    reset = 1'b0;
    next_cyc();
    chk("post_rst_valid", 64'(bus.ID_EX_Valid), 64'h1);
    chk("post_rst_rd1",   bus.ID_EX_ReadData1, 64'hABCD);
    next_cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus load-use hazard detection for the 5-stage RV64 core.
- Captures decode-stage operands, immediate, PC and control bits every cycle.
- Drives the ID_EX_RegisterRs1/Rs2/Rd and control fields consumed by the EX-stage forwarding unit and ALU.
- Stalls IF/ID on load-use hazards, inserts bubbles, and honours branch flush and external hold.

Parameters:
- DATA_W, 64: datapath width (operands, immediate, PC).
- REG_ADDR_W, 5: register-index width.
- CNT_W, 32: width of the stall and bubble performance counters.

Ports:
- clk  input  1  single pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- IF_ID_RegisterRs1  input  REG_ADDR_W  rs1 index of the instruction in decode.
- IF_ID_RegisterRs2  input  REG_ADDR_W  rs2 index of the instruction in decode.
- IF_ID_RegisterRd  input  REG_ADDR_W  rd index of the instruction in decode.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Branch, ID_ALUSrc  input  1 each  decoded control bits.
- ID_ALUOp  input  2  decoded ALU op class.
- ID_Funct  input  4  {funct7[5], funct3}.
- ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC  input  DATA_W each  decode-stage data.
- flush  input  1  branch taken, resolved in EX/MEM; kill the decode instruction.
- hold  input  1  global stall (e.g. memory busy); freeze this stage.
- ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd  output  REG_ADDR_W each  registered indices, to forwarding unit.
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Branch, ID_EX_ALUSrc  output  1 each  registered control bits.
- ID_EX_ALUOp  output  2  registered ALU op class.
- ID_EX_Funct  output  4  registered funct bits.
- ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC  output  DATA_W each  registered data.
- ID_EX_Valid  output  1  1 = real instruction, 0 = bubble.
- PCWrite  output  1  0 = freeze PC.
- IF_ID_Write  output  1  0 = freeze IF/ID register.
- stall_count  output  CNT_W  load-use stall cycles, saturating.
- bubble_count  output  CNT_W  bubbles inserted for any reason, saturating.

Behaviour:
- Reset (async, asserted): every registered output clears to 0, including ID_EX_Valid and both counters. PCWrite and IF_ID_Write read 1 while reset is asserted.
- Load-use hazard (combinational, from registered state only):
  - lu = ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegisterRd != 0) & (ID_EX_RegisterRd == IF_ID_RegisterRs1 | ID_EX_RegisterRd == IF_ID_RegisterRs2).
  - rs2 is compared unconditionally; a false stall on I-type instructions is accepted.
- Per-edge update, strict priority flush > hold > lu > normal:
  - flush: load a bubble (all control bits, indices, data and Valid = 0). bubble_count += 1.
  - hold (no flush): all ID/EX registers retain their values. Counters unchanged.
  - lu (no flush, no hold): load a bubble. stall_count += 1 and bubble_count += 1.
  - normal: capture all ID_* inputs and set Valid = 1.
- PCWrite = IF_ID_Write = ~(hold | (lu & ~flush)), combinational.
  - flush overrides lu: upstream must advance to the branch target.
- Latency: one cycle, decode inputs to ID_EX_* outputs.
- Load-use stall lasts exactly one cycle. The bubble clears ID_EX_MemRead, so lu self-deasserts on the next cycle.
- Back-to-back loads each stall at most once.
- hold during lu: the stage freezes, so lu persists. stall_count does not increment until hold drops.
- Counters saturate at all ones; no wrap.
- rd = x0 never causes a stall.
- Reset asserted mid-stall clears the stage immediately. After release, the first edge is a normal capture unless flush or hold is high.

Test Plan:
- Reset: assert reset mid-stream -> all ID_EX_* = 0, Valid = 0, PCWrite = 1, counters = 0, all without waiting for a clock edge.
- Load-use: `ld x5` in EX, decode rs1 = 5 -> PCWrite = 0 and IF_ID_Write = 0 for 1 cycle, bubble in EX (Valid = 0, MemRead = 0), stall_count = 1; next cycle the dependent instruction is captured with Valid = 1.
- x0 / non-load: `ld x0` with decode rs1 = 0 -> no stall. An `add x5` producer with rs1 = 5 -> no stall. stall_count stays 0.
- Flush vs lu: flush = 1 in the same cycle as lu -> PCWrite = 1, bubble inserted, bubble_count = 1, stall_count = 0.
- Hold: hold = 1 for 3 cycles with ReadData1 = 0xDEAD_BEEF latched -> outputs unchanged across all 3 edges, PCWrite = 0, counters unchanged; on release the next decode instruction is captured.
- Saturation: preload counters near max (force or long lu stream) -> stall_count reaches 0xFFFF_FFFF and holds there.
